mc_hawkes_event_sampler: RTL
============================

// Module: mc_hawkes_event_sampler
// PURPOSE
//  Upstream event source for the Monte Carlo mean-price engine. Simulates one path of a 4-dim
//  discrete-time Hawkes process (types 0..3 = bid-up, bid-down, ask-up, ask-down).
//  Streams one (type, tick) record per event over a valid/ready port to the price stage.
//  Uses a single shared multiplier and a 16-bit LFSR; runs num_steps ticks per start pulse.
// PARAMETERS
//  DT_SHIFT  6       tick length dt = 2^-DT_SHIFT time units (range 0..12)
//  SEED      16'hACE1 LFSR reset/seed value (must be nonzero)
// PORTS
//  clk        in   1    clock
//  rst        in   1    async reset, active-high
//  start      in   1    begin a path; ignored while busy
//  num_steps  in   16   ticks to simulate, latched at start
//  alfa_flat  in   128  alfa[i][j] at [(4i+j)*8 +: 8], 4.4 unsigned (excitation of i by j)
//  beta_flat  in   128  beta[i][j], same packing, 4.4 unsigned decay rate
//  mu_flat    in   32   mu[i] at [i*8 +: 8], 4.4 unsigned base rate
//  evt_valid  out  1    event record valid
//  evt_ready  in   1    downstream accepts record
//  evt_type   out  2    event dimension j
//  evt_tick   out  16   tick index of event (0-based)
//  busy       out  1    path in progress
//  done       out  1    one-cycle pulse at end of path
// BEHAVIOUR
//  Reset: all outputs 0; x[i][j]=0; step_cnt=0; LFSR=SEED; FSM=IDLE.
//  alfa/beta/mu latched at start; input changes mid-path have no effect.
//  State x[i][j]: 12-bit unsigned 8.4, saturates at 4095, never below 0.
//  FSM: IDLE -start-> DECAY (num_steps==0 -> DONE).
//   DECAY 16 cycles, one (i,j) per cycle, i-major: x -= (x*beta)>>(4+DT_SHIFT) (20-bit product).
//   SAMPLE 4 cycles, i=0..3: lambda_i=mu_i+sum_j x[i][j] (14 bit, 10.4); LFSR advances once;
//    hit_i = U < (lambda_i << (12-DT_SHIFT)) (26-bit compare). First hit in order 0..3 wins;
//    remaining SAMPLE cycles still run (LFSR consumption is fixed at 4 per tick).
//   After SAMPLE: hit -> EMIT, else UPDATE.
//   EMIT: evt_valid=1, type/tick stable until evt_valid&&evt_ready; then UPDATE.
//   UPDATE 1 cycle: if an event of type j occurred, x[i][j]+=alfa[i][j] for all i (saturating);
//    step_cnt==num_steps-1 -> DONE else step_cnt++ -> DECAY.
//   DONE: done=1 one cycle, busy=0 next cycle, -> IDLE.
//  Latency: start->done = 21*N+1 cycles plus handshake cycles, with N = num_steps
//   (N=0 -> done 1 cycle after start).
//   busy=1 from cycle after start through the DONE cycle.
//  At most one event per tick; evt_valid is never dropped without a handshake.
//  Reset mid-path aborts immediately; no done pulse; LFSR reseeded.
//  start in the same cycle as DONE is ignored.
// CONFIGURATION
//  HAWKES_EVT_COUNT_EN defined: extra output evt_count_flat[63:0], 16-bit per-type counters
//   at [j*16 +: 16], cleared at start and reset, increment on handshake, saturate at 16'hFFFF.
//  Undefined: port and counters absent; behaviour otherwise identical.
// STRUCTURE
//  Package mc_hawkes_pkg: NDIM=4, PARAM_W=8, X_W=12, LAMBDA_W=14, FRAC_BITS=4,
//   evt_type enum (BID_UP, BID_DN, ASK_UP, ASK_DN), FSM state enum.
//  Sub-module mc_lfsr16: Galois LFSR x^16+x^14+x^13+x^11+1, ports clk, rst, seed, adv, q.
// TESTING
//  Reset mid-path at step 5 -> all outputs 0, busy 0, LFSR==SEED, no done pulse.
//  num_steps=0, start -> done exactly 1 cycle later, no evt_valid.
//  mu=alfa=0, num_steps=100, evt_ready=1 -> no events, done 2101 cycles after start.
//  mu0=8'hFF, others 0, alfa=0, DT_SHIFT=6, 4000 steps -> only type 0, count in 900..1100.
//  evt_ready low 10 cycles during EMIT -> evt_valid/type/tick held, step_cnt frozen.
//  alfa00=8'h10, beta00=8'hF0, forced type-0 event -> x00=16 after UPDATE, 13 after next DECAY.

Source files
------------

// File: rtl/mc_hawkes_pkg.sv
// ============================================================================
// mc_hawkes_pkg : shared widths, event/state encodings and saturating helper
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

package mc_hawkes_pkg;

   localparam int NDIM      = 4;
   localparam int PARAM_W   = 8;
   localparam int X_W       = 12;
   localparam int LAMBDA_W  = 14;
   localparam int FRAC_BITS = 4;

   typedef enum logic [1:0] {
      BID_UP = 2'd0,
      BID_DN = 2'd1,
      ASK_UP = 2'd2,
      ASK_DN = 2'd3
   } evt_type_e;

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_DECAY  = 3'd1,
      S_SAMPLE = 3'd2,
      S_EMIT   = 3'd3,
      S_UPDATE = 3'd4,
      S_DONE   = 3'd5
   } state_e;

   function automatic logic [X_W-1:0] x_sat_add(input logic [X_W-1:0] x,
                                                 input logic [PARAM_W-1:0] a);
      logic [X_W:0] s;
      s = {1'b0, x} + {{(X_W-PARAM_W+1){1'b0}}, a};
      return s[X_W] ? '1 : s[X_W-1:0];
   endfunction

endpackage

`default_nettype wire

// File: rtl/mc_lfsr16.sv
// ============================================================================
// mc_lfsr16 : 16-bit Galois LFSR, x^16+x^14+x^13+x^11+1, advances when adv=1
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module mc_lfsr16 (
   input  logic        clk,
   input  logic        rst,
   input  logic [15:0] seed,
   input  logic        adv,
   output logic [15:0] q
);

   logic [15:0] q_q, q_d;

   always_comb begin
      q_d = q_q;
      if (adv) begin
         q_d = {1'b0, q_q[15:1]} ^ (q_q[0] ? 16'hB400 : 16'h0000);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         q_q <= seed;
      end else begin
         q_q <= q_d;
      end
   end

   assign q = q_q;

endmodule

`default_nettype wire

// File: rtl/mc_hawkes_event_sampler.sv
// ============================================================================
// mc_hawkes_event_sampler : 4-dim discrete-time Hawkes path simulator that
// streams (type, tick) event records. HAWKES_EVT_COUNT_EN adds per-type counters.
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module mc_hawkes_event_sampler
   import mc_hawkes_pkg::*;
#(
   parameter int          DT_SHIFT = 6,
   parameter logic [15:0] SEED     = 16'hACE1
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         start,
   input  logic [15:0]  num_steps,
   input  logic [127:0] alfa_flat,
   input  logic [127:0] beta_flat,
   input  logic [31:0]  mu_flat,
   output logic         evt_valid,
   input  logic         evt_ready,
   output logic [1:0]   evt_type,
   output logic [15:0]  evt_tick,
   output logic         busy,
   output logic         done
`ifdef HAWKES_EVT_COUNT_EN
   ,
   output logic [63:0]  evt_count_flat
`endif
);

   localparam int NX    = NDIM * NDIM;
   localparam int PW    = X_W + PARAM_W;
   localparam int THR_W = LAMBDA_W + 12;

   state_e                   state_q, state_d;
   logic [3:0]               idx_q, idx_d;
   logic [15:0]              step_cnt_q, step_cnt_d;
   logic [15:0]              num_steps_q, num_steps_d;
   logic [NX*PARAM_W-1:0]    alfa_q, alfa_d, beta_q, beta_d;
   logic [NDIM*PARAM_W-1:0]  mu_q, mu_d;
   logic [X_W-1:0]           x_q [NX];
   logic [X_W-1:0]           x_d [NX];
   logic                     hit_q, hit_d;
   evt_type_e                type_q, type_d;

   logic [15:0]              lfsr_q;
   logic                     lfsr_adv;

   logic [X_W-1:0]           w_x_cur, w_x_decayed;
   logic [PARAM_W-1:0]       w_beta_cur;
   logic [PW-1:0]            w_prod, w_dec;
   logic [1:0]               w_row;
   logic [LAMBDA_W:0]        w_lambda_sum;
   logic [LAMBDA_W-1:0]      w_lambda;
   logic [THR_W-1:0]         w_thresh;
   logic                     w_hit;

   // Shared multiplier: one (i,j) decay term per DECAY cycle.
   assign w_x_cur     = x_q[idx_q];
   assign w_beta_cur  = beta_q[{idx_q, 3'b000} +: PARAM_W];
   assign w_prod      = {{PARAM_W{1'b0}}, w_x_cur} * {{X_W{1'b0}}, w_beta_cur};
   assign w_dec       = w_prod >> (FRAC_BITS + DT_SHIFT);
   assign w_x_decayed = (w_dec > {{PARAM_W{1'b0}}, w_x_cur}) ? '0 : (w_x_cur - w_dec[X_W-1:0]);

   assign w_row = idx_q[1:0];

   always_comb begin
      w_lambda_sum = (LAMBDA_W+1)'(mu_q[{w_row, 3'b000} +: PARAM_W]);
      for (int j = 0; j < NDIM; j++) begin
         w_lambda_sum = w_lambda_sum + (LAMBDA_W+1)'(x_q[{w_row, j[1:0]}]);
      end
   end

   assign w_lambda = w_lambda_sum[LAMBDA_W] ? '1 : w_lambda_sum[LAMBDA_W-1:0];
   assign w_thresh = THR_W'(w_lambda) << (12 - DT_SHIFT);
   assign w_hit    = THR_W'(lfsr_q) < w_thresh;
   assign lfsr_adv = (state_q == S_SAMPLE);

   mc_lfsr16 u_lfsr (
      .clk  (clk),
      .rst  (rst),
      .seed (SEED),
      .adv  (lfsr_adv),
      .q    (lfsr_q)
   );

   always_comb begin
      state_d     = state_q;
      idx_d       = idx_q;
      step_cnt_d  = step_cnt_q;
      num_steps_d = num_steps_q;
      alfa_d      = alfa_q;
      beta_d      = beta_q;
      mu_d        = mu_q;
      x_d         = x_q;
      hit_d       = hit_q;
      type_d      = type_q;

      case (state_q)
         S_IDLE: begin
            if (start) begin
               num_steps_d = num_steps;
               alfa_d      = alfa_flat;
               beta_d      = beta_flat;
               mu_d        = mu_flat;
               step_cnt_d  = '0;
               idx_d       = '0;
               hit_d       = 1'b0;
               for (int k = 0; k < NX; k++) begin
                  x_d[k] = '0;
               end
               state_d = (num_steps == 16'd0) ? S_DONE : S_DECAY;
            end
         end
         S_DECAY: begin
            x_d[idx_q] = w_x_decayed;
            idx_d      = idx_q + 4'd1;
            if (idx_q == 4'(NX-1)) begin
               state_d = S_SAMPLE;
            end
         end
         S_SAMPLE: begin
            // Only the first hit in type order is kept; all four draws are still consumed.
            if (!hit_q && w_hit) begin
               hit_d  = 1'b1;
               type_d = evt_type_e'(w_row);
            end
            idx_d = idx_q + 4'd1;
            if (w_row == 2'(NDIM-1)) begin
               idx_d   = '0;
               state_d = hit_d ? S_EMIT : S_UPDATE;
            end
         end
         S_EMIT: begin
            if (evt_ready) begin
               state_d = S_UPDATE;
            end
         end
         S_UPDATE: begin
            if (hit_q) begin
               for (int i = 0; i < NDIM; i++) begin
                  x_d[{i[1:0], type_q}] = x_sat_add(x_q[{i[1:0], type_q}],
                                                    alfa_q[{i[1:0], type_q, 3'b000} +: PARAM_W]);
               end
            end
            hit_d = 1'b0;
            if (step_cnt_q == num_steps_q - 16'd1) begin
               state_d = S_DONE;
            end else begin
               step_cnt_d = step_cnt_q + 16'd1;
               state_d    = S_DECAY;
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= S_IDLE;
         idx_q       <= '0;
         step_cnt_q  <= '0;
         num_steps_q <= '0;
         alfa_q      <= '0;
         beta_q      <= '0;
         mu_q        <= '0;
         hit_q       <= 1'b0;
         type_q      <= BID_UP;
         for (int k = 0; k < NX; k++) begin
            x_q[k] <= '0;
         end
      end else begin
         state_q     <= state_d;
         idx_q       <= idx_d;
         step_cnt_q  <= step_cnt_d;
         num_steps_q <= num_steps_d;
         alfa_q      <= alfa_d;
         beta_q      <= beta_d;
         mu_q        <= mu_d;
         hit_q       <= hit_d;
         type_q      <= type_d;
         x_q         <= x_d;
      end
   end

   assign evt_valid = (state_q == S_EMIT);
   assign evt_type  = type_q;
   assign evt_tick  = step_cnt_q;
   assign busy      = (state_q != S_IDLE);
   assign done      = (state_q == S_DONE);

`ifdef HAWKES_EVT_COUNT_EN
   logic [15:0] cnt_q [NDIM];
   logic [15:0] cnt_d [NDIM];

   always_comb begin
      cnt_d = cnt_q;
      if (state_q == S_IDLE && start) begin
         for (int j = 0; j < NDIM; j++) begin
            cnt_d[j] = '0;
         end
      end else if (state_q == S_EMIT && evt_ready && cnt_q[type_q] != 16'hFFFF) begin
         cnt_d[type_q] = cnt_q[type_q] + 16'd1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int j = 0; j < NDIM; j++) begin
            cnt_q[j] <= '0;
         end
      end else begin
         cnt_q <= cnt_d;
      end
   end

   for (genvar g = 0; g < NDIM; g++) begin : g_cnt_out
      assign evt_count_flat[g*16 +: 16] = cnt_q[g];
   end
`endif

endmodule

`default_nettype wire
